audio_sample_sched: RTL and testbench
=====================================

AUDIO_SAMPLE_SCHED -- requirements
Module: audio_sample_sched

Interface
REQ-001 Parameter FRAME_W, default 12, frame counter width; the PWM frame is 2^FRAME_W clocks.
REQ-002 Parameter DATA_W, default 8, sample/duty width.
REQ-003 CLK  input  1  system clock; all logic on posedge CLK.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 en  input  1  playback enable; 1 = start/continue, 0 = fade out and stop.
REQ-006 vol_target  input  4  requested volume, sampled every frame tick.
REQ-007 s_valid  input  2  per-source sample valid (bit 0 = source 0, bit 1 = source 1).
REQ-008 s_data0, s_data1  input  DATA_W  sample data from source 0 and source 1.
REQ-009 s_ready  output  2  per-source ready; transfer when s_valid[i] & s_ready[i].
REQ-010 duty  output  DATA_W  registered duty value to the PWM.
REQ-011 VOL  output  4  registered volume to the PWM.
REQ-012 frame_tick  output  1  one-cycle pulse, high when frame counter = 2^FRAME_W-1.
REQ-013 underrun  output  1  one-cycle pulse on an underrun frame tick.
REQ-014 underrun_cnt  output  8  saturating underrun count.
REQ-015 state  output  2  current FSM state code, for debug.

Function
REQ-016 Free-running FRAME_W-bit counter; increments every cycle and wraps from all-ones to 0; frame_tick is combinational from counter = all-ones, so it aligns with the PWM latch point.
REQ-017 FSM states: IDLE=0, RAMP_UP=1, PLAY=2, RAMP_DOWN=3; all transitions occur only on frame_tick cycles.
REQ-018 IDLE: VOL=0, duty held, s_ready=0; on tick with en=1 and vol_target>0 -> RAMP_UP.
REQ-019 RAMP_UP: VOL += 1 per tick; on reaching vol_target -> PLAY; en=0 on any tick -> RAMP_DOWN (that tick's VOL step is a decrement).
REQ-020 PLAY: VOL steps by ±1 per tick toward vol_target and never jumps; en=0 -> RAMP_DOWN.
REQ-021 RAMP_DOWN: VOL -= 1 per tick; on the tick where VOL becomes 0 -> IDLE; en=1 during the ramp -> RAMP_UP.
REQ-022 vol_target=0 in PLAY ramps VOL to 0 and stays in PLAY; VOL arithmetic never wraps (clamped to 0..15).
REQ-023 Arbitration, in states other than IDLE, on frame_tick only: s_ready is combinational, at most one bit high, and asserted only to the granted valid source.
REQ-024 Grant rule:
- both sources valid: round-robin, preferring the source not granted at the last transfer (source 0 preferred after reset);
- one source valid: that source;
- no source valid: no grant.
REQ-025 On transfer, duty <= granted data on the same edge, so the new duty is visible from counter = 0 (latency 1 cycle).
REQ-026 Tick with no valid source in a non-IDLE state:
- duty holds its previous value;
- underrun pulses for 1 cycle;
- underrun_cnt increments, saturating at 255.
REQ-027 s_ready=0 on every non-tick cycle; held s_valid and data are not consumed between ticks.
REQ-028 Leaving RAMP_DOWN to IDLE sets duty <= 0 on that tick.

Reset
REQ-029 RST (synchronous) sets: counter=0, state=IDLE, duty=0, VOL=0, underrun_cnt=0, round-robin pointer to prefer source 0; s_ready, underrun and frame_tick are 0 while RST is high.
REQ-030 RST mid-ramp or mid-transfer aborts immediately with no partial update; the first frame_tick follows 2^FRAME_W cycles after RST falls.

Structure
REQ-031 A shared package audio_pkg holds the state encoding, FRAME_W/DATA_W defaults and VOL_MAX=15.
REQ-032 The 2-way round-robin arbiter is a separate sub-module rr_arb2 (inputs req[1:0] and tick, output one-hot gnt[1:0]); everything else is flat.

Verification (FRAME_W=4 allowed for sim)
REQ-033 en=1, vol_target=3, s_valid=01 constant -> VOL sequence 1,2,3 on successive ticks, state RAMP_UP->PLAY after tick 3, and duty=s_data0 from the cycle after each tick.
REQ-034 Both sources valid continuously, data0=0x11, data1=0x22 -> duty alternates 0x11, 0x22, 0x11 per frame; exactly one s_ready bit high, only on tick cycles.
REQ-035 In PLAY, s_valid=00 for 3 ticks -> duty unchanged, 3 underrun pulses, underrun_cnt=3; 300 underruns -> underrun_cnt=255.
REQ-036 In PLAY with VOL=5, en=0 -> VOL 4,3,2,1,0 on successive ticks, then IDLE, duty=0, s_ready stays 0.
REQ-037 In RAMP_DOWN at VOL=2, en=1 -> VOL 3 at next tick, state RAMP_UP; vol_target changed 10->4 in PLAY -> VOL decrements by 1 per tick to 4.
REQ-038 RST asserted one cycle mid-RAMP_UP -> next cycle VOL=0, duty=0, state=IDLE, counter=0.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared state encoding, defaults and volume helpers for the audio scheduler
package audio_pkg;

    localparam int FRAME_W_DEF = 12;
    localparam int DATA_W_DEF  = 8;
    localparam logic [3:0] VOL_MAX = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_PLAY      = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } sched_state_t;

    // One volume step, clamped to 0..VOL_MAX so the ramp never wraps.
    function automatic logic [3:0] vol_step(input logic [3:0] v, input logic up);
        if (up)
            return (v == VOL_MAX) ? v : v + 4'd1;
        else
            return (v == 4'd0) ? v : v - 4'd1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, grants only while tick is high
module rr_arb2 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       tick,
    output logic [1:0] gnt
);

    logic pref;

    always_comb begin
        gnt = 2'b00;
        if (tick) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = pref ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // After granting source 0 the next contested tick favours source 1, and vice versa.
    always_ff @(posedge CLK) begin
        if (RST)
            pref <= 1'b0;
        else if (|gnt)
            pref <= gnt[0];
    end

endmodule

// File: rtl/audio_sample_sched.sv
// rtl/audio_sample_sched.sv - frame-rate sample scheduler with volume ramping and underrun tracking
module audio_sample_sched
    import audio_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic [3:0]        vol_target,
    input  logic [1:0]        s_valid,
    input  logic [DATA_W-1:0] s_data0,
    input  logic [DATA_W-1:0] s_data1,
    output logic [1:0]        s_ready,
    output logic [DATA_W-1:0] duty,
    output logic [3:0]        VOL,
    output logic              frame_tick,
    output logic              underrun,
    output logic [7:0]        underrun_cnt,
    output logic [1:0]        state
);

    logic [FRAME_W-1:0] frame_cnt;
    sched_state_t       st;
    logic               arb_en;
    logic [1:0]         gnt;
    logic [3:0]         vol_up;
    logic [3:0]         vol_dn;

    assign frame_tick = (&frame_cnt) & ~RST;
    assign arb_en     = (st != ST_IDLE);
    assign underrun   = frame_tick & arb_en & (s_valid == 2'b00);
    assign s_ready    = gnt;
    assign state      = st;
    assign vol_up     = vol_step(VOL, 1'b1);
    assign vol_dn     = vol_step(VOL, 1'b0);

    rr_arb2 u_arb (
        .CLK  (CLK),
        .RST  (RST),
        .req  (s_valid & {2{arb_en}}),
        .tick (frame_tick),
        .gnt  (gnt)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_cnt    <= '0;
            st           <= ST_IDLE;
            duty         <= '0;
            VOL          <= 4'd0;
            underrun_cnt <= 8'd0;
        end else begin
            frame_cnt <= frame_cnt + 1'b1;
            if (frame_tick) begin
                if (gnt[0])
                    duty <= s_data0;
                else if (gnt[1])
                    duty <= s_data1;
                if (underrun && underrun_cnt != 8'hFF)
                    underrun_cnt <= underrun_cnt + 8'd1;

                // Fading out takes priority in every active state; reaching silence parks in IDLE.
                if (st != ST_IDLE && !en) begin
                    VOL <= vol_dn;
                    if (vol_dn == 4'd0) begin
                        st   <= ST_IDLE;
                        duty <= '0;
                    end else begin
                        st <= ST_RAMP_DOWN;
                    end
                end else begin
                    case (st)
                        ST_IDLE: begin
                            if (en && vol_target != 4'd0) begin
                                VOL <= vol_up;
                                st  <= (vol_up == vol_target) ? ST_PLAY : ST_RAMP_UP;
                            end
                        end
                        ST_RAMP_UP: begin
                            if (VOL < vol_target) begin
                                VOL <= vol_up;
                                if (vol_up == vol_target)
                                    st <= ST_PLAY;
                            end else begin
                                st <= ST_PLAY;
                                if (VOL > vol_target)
                                    VOL <= vol_dn;
                            end
                        end
                        ST_PLAY: begin
                            if (VOL < vol_target)
                                VOL <= vol_up;
                            else if (VOL > vol_target)
                                VOL <= vol_dn;
                        end
                        ST_RAMP_DOWN: begin
                            VOL <= vol_up;
                            st  <= ST_RAMP_UP;
                        end
                        default: st <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_sched.sv
// tb/tb_audio_sample_sched.sv - table-driven self-checking bench for audio_sample_sched
module tb_audio_sample_sched;

    localparam int FW = 4;
    localparam int DW = 8;
    localparam int TICK_GAP = (1 << FW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          en = 1'b0;
    logic [3:0]    vol_target = 4'd0;
    logic [1:0]    s_valid = 2'b00;
    logic [DW-1:0] s_data0 = '0;
    logic [DW-1:0] s_data1 = '0;
    logic [1:0]    s_ready;
    logic [DW-1:0] duty;
    logic [3:0]    VOL;
    logic          frame_tick;
    logic          underrun;
    logic [7:0]    underrun_cnt;
    logic [1:0]    state;

    int checks = 0;
    int failures = 0;

    audio_sample_sched #(.FRAME_W(FW), .DATA_W(DW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .en           (en),
        .vol_target   (vol_target),
        .s_valid      (s_valid),
        .s_data0      (s_data0),
        .s_data1      (s_data1),
        .s_ready      (s_ready),
        .duty         (duty),
        .VOL          (VOL),
        .frame_tick   (frame_tick),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .state        (state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          en;
        logic [3:0]    tgt;
        logic [1:0]    vld;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [1:0]    rdy;
        logic          und;
        logic [3:0]    vol;
        logic [1:0]    st;
        logic [DW-1:0] duty;
        logic [7:0]    ucnt;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Advance to the next frame_tick cycle; outputs are sampled on the falling edge.
    task automatic to_tick(output int n);
        bit stray;
        n = 0;
        stray = 0;
        do begin
            @(negedge CLK);
            n++;
            if (!frame_tick && (s_ready != 2'b00 || underrun))
                stray = 1;
        end while (!frame_tick && n < 64);
        chk("tick_seen", 32'(frame_tick), 32'd1);
        chk("quiet_between_ticks", 32'(stray), 32'd0);
    endtask

    initial begin
        int n;
        int pulses;

        //           en tgt  vld    d0     d1    rdy  und vol st  duty  ucnt
        tbl[0]  = '{1'b1, 4'd3,  2'b01, 8'hA1, 8'h22, 2'b00, 1'b0, 4'd1, 2'd1, 8'h00, 8'd0};
        tbl[1]  = '{1'b1, 4'd3,  2'b01, 8'hA2, 8'h22, 2'b01, 1'b0, 4'd2, 2'd1, 8'hA2, 8'd0};
        tbl[2]  = '{1'b1, 4'd3,  2'b01, 8'hA3, 8'h22, 2'b01, 1'b0, 4'd3, 2'd2, 8'hA3, 8'd0};
        tbl[3]  = '{1'b1, 4'd3,  2'b11, 8'h11, 8'h22, 2'b10, 1'b0, 4'd3, 2'd2, 8'h22, 8'd0};
        tbl[4]  = '{1'b1, 4'd3,  2'b11, 8'h11, 8'h22, 2'b01, 1'b0, 4'd3, 2'd2, 8'h11, 8'd0};
        tbl[5]  = '{1'b1, 4'd3,  2'b11, 8'h11, 8'h22, 2'b10, 1'b0, 4'd3, 2'd2, 8'h22, 8'd0};
        tbl[6]  = '{1'b1, 4'd3,  2'b00, 8'h11, 8'h22, 2'b00, 1'b1, 4'd3, 2'd2, 8'h22, 8'd1};
        tbl[7]  = '{1'b1, 4'd3,  2'b00, 8'h11, 8'h22, 2'b00, 1'b1, 4'd3, 2'd2, 8'h22, 8'd2};
        tbl[8]  = '{1'b1, 4'd3,  2'b00, 8'h11, 8'h22, 2'b00, 1'b1, 4'd3, 2'd2, 8'h22, 8'd3};
        tbl[9]  = '{1'b1, 4'd5,  2'b10, 8'h33, 8'h5A, 2'b10, 1'b0, 4'd4, 2'd2, 8'h5A, 8'd3};
        tbl[10] = '{1'b1, 4'd5,  2'b01, 8'h33, 8'h5A, 2'b01, 1'b0, 4'd5, 2'd2, 8'h33, 8'd3};
        tbl[11] = '{1'b0, 4'd5,  2'b01, 8'h44, 8'h5A, 2'b01, 1'b0, 4'd4, 2'd3, 8'h44, 8'd3};
        tbl[12] = '{1'b0, 4'd5,  2'b01, 8'h44, 8'h5A, 2'b01, 1'b0, 4'd3, 2'd3, 8'h44, 8'd3};
        tbl[13] = '{1'b0, 4'd5,  2'b01, 8'h44, 8'h5A, 2'b01, 1'b0, 4'd2, 2'd3, 8'h44, 8'd3};
        tbl[14] = '{1'b1, 4'd10, 2'b01, 8'h44, 8'h5A, 2'b01, 1'b0, 4'd3, 2'd1, 8'h44, 8'd3};
        tbl[15] = '{1'b0, 4'd10, 2'b01, 8'h45, 8'h5A, 2'b01, 1'b0, 4'd2, 2'd3, 8'h45, 8'd3};
        tbl[16] = '{1'b0, 4'd10, 2'b01, 8'h46, 8'h5A, 2'b01, 1'b0, 4'd1, 2'd3, 8'h46, 8'd3};
        tbl[17] = '{1'b0, 4'd10, 2'b01, 8'h47, 8'h5A, 2'b01, 1'b0, 4'd0, 2'd0, 8'h00, 8'd3};
        tbl[18] = '{1'b0, 4'd10, 2'b01, 8'h48, 8'h5A, 2'b00, 1'b0, 4'd0, 2'd0, 8'h00, 8'd3};

        repeat (3) @(negedge CLK);
        chk("rst_vol", 32'(VOL), 32'd0);
        chk("rst_duty", 32'(duty), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ucnt", 32'(underrun_cnt), 32'd0);
        chk("rst_outs", 32'({s_ready, underrun, frame_tick}), 32'd0);
        RST = 1'b0;

        for (int i = 0; i < 19; i++) begin
            en = tbl[i].en;
            vol_target = tbl[i].tgt;
            s_valid = tbl[i].vld;
            s_data0 = tbl[i].d0;
            s_data1 = tbl[i].d1;
            to_tick(n);
            if (i == 0)
                chk("first_tick_gap", 32'(n), 32'(TICK_GAP));
            chk($sformatf("row%0d_ready", i), 32'(s_ready), 32'(tbl[i].rdy));
            chk($sformatf("row%0d_underrun", i), 32'(underrun), 32'(tbl[i].und));
            @(negedge CLK);
            chk($sformatf("row%0d_vol", i), 32'(VOL), 32'(tbl[i].vol));
            chk($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("row%0d_duty", i), 32'(duty), 32'(tbl[i].duty));
            chk($sformatf("row%0d_ucnt", i), 32'(underrun_cnt), 32'(tbl[i].ucnt));
        end

        // Ramp 0 -> 10, then retarget to 4 while playing.
        en = 1'b1; vol_target = 4'd10; s_valid = 2'b01; s_data0 = 8'h66;
        for (int v = 1; v <= 10; v++) begin
            to_tick(n);
            @(negedge CLK);
            chk($sformatf("ramp_up_vol%0d", v), 32'(VOL), 32'(v));
        end
        chk("ramp_up_play", 32'(state), 32'd2);
        vol_target = 4'd4;
        for (int v = 9; v >= 3; v--) begin
            to_tick(n);
            @(negedge CLK);
            chk($sformatf("retarget_vol%0d", v), 32'(VOL), 32'(v < 4 ? 4 : v));
            chk("retarget_state", 32'(state), 32'd2);
        end

        // 300 starved ticks: one pulse each, counter pins at 255.
        s_valid = 2'b00;
        pulses = 0;
        for (int k = 0; k < 300; k++) begin
            to_tick(n);
            if (underrun) pulses++;
            @(negedge CLK);
        end
        chk("sat_pulses", 32'(pulses), 32'd300);
        chk("sat_ucnt", 32'(underrun_cnt), 32'd255);
        chk("sat_duty_held", 32'(duty), 32'h66);

        // Target 0 while playing fades but stays in PLAY.
        s_valid = 2'b01; vol_target = 4'd0;
        for (int v = 3; v >= -1; v--) begin
            to_tick(n);
            @(negedge CLK);
            chk($sformatf("zero_tgt_vol%0d", v), 32'(VOL), 32'(v < 0 ? 0 : v));
            chk("zero_tgt_state", 32'(state), 32'd2);
        end
        en = 1'b0;
        to_tick(n);
        @(negedge CLK);
        chk("silent_exit_state", 32'(state), 32'd0);

        // Reset pulse in the middle of a ramp.
        en = 1'b1; vol_target = 4'd5; s_data0 = 8'h55;
        to_tick(n);
        @(negedge CLK);
        to_tick(n);
        @(negedge CLK);
        chk("pre_rst_vol", 32'(VOL), 32'd2);
        chk("pre_rst_duty", 32'(duty), 32'h55);
        chk("pre_rst_state", 32'(state), 32'd1);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("mid_rst_outs", 32'({s_ready, underrun, frame_tick}), 32'd0);
        RST = 1'b0;
        chk("post_rst_vol", 32'(VOL), 32'd0);
        chk("post_rst_duty", 32'(duty), 32'd0);
        chk("post_rst_state", 32'(state), 32'd0);
        chk("post_rst_ucnt", 32'(underrun_cnt), 32'd0);
        to_tick(n);
        chk("post_rst_tick_gap", 32'(n), 32'(TICK_GAP));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
